uart_tx_fsm: RTL and testbench

Frame controller for the UART transmit path. Accepts a parallel byte with a valid strobe and latches it with its parity configuration. Drives the 8-bit serializer stage (enable out, serial bit and done flag in) and multiplexes start, data, parity and stop bits onto the line. One clock cycle is one bit time; the clock is the baud clock.

---
 rtl/uart_tx_pkg.sv | 42 ++++
 rtl/uart_tx_mux.sv | 34 +++
 rtl/uart_tx_fsm.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_fsm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared definitions for the UART transmit frame controller.
//               Holds the payload width, the frame state encoding, the
//               line-mux select codes and the parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    // Payload width; the attached serializer is fixed at 8 bits.
    localparam int DATA_W = 8;

    // Frame state encoding (3-bit, kept as plain constants so that legacy
    // code comparing against raw values keeps working).
    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t START  = 3'd1;
    localparam state_t DATA   = 3'd2;
    localparam state_t PARITY = 3'd3;
    localparam state_t STOP   = 3'd4;

    // Line multiplexer select codes.
    typedef logic [1:0] sel_t;

    localparam sel_t SEL_START = 2'd0;  // drive 0
    localparam sel_t SEL_DATA  = 2'd1;  // drive serializer bit
    localparam sel_t SEL_PAR   = 2'd2;  // drive parity bit
    localparam sel_t SEL_STOP  = 2'd3;  // drive 1 (stop bit and idle)

    // Parity bit for a byte: even parity gives XOR of all bits, odd parity
    // inverts it so that the total count of ones on the line is odd.
    function automatic logic parity_bit(
        input logic [DATA_W-1:0] data,
        input logic              odd
    );
        return (^data) ^ odd;
    endfunction

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_tx_mux.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_mux
// Description : 4:1 combinational line selector for the UART transmitter.
//               Chooses between start bit (0), serializer data, parity bit
//               and stop/idle level (1).
// Ports       : i_sel      - select code (SEL_START/SEL_DATA/SEL_PAR/SEL_STOP)
//               i_ser_data - current serial bit from the serializer
//               i_parity   - precomputed parity bit
//               o_line     - UART line level
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_mux
    import uart_tx_pkg::*;
(
    input  logic [1:0] i_sel,
    input  logic       i_ser_data,
    input  logic       i_parity,
    output logic       o_line
);

    always_comb begin
        o_line = 1'b1;
        case (i_sel)
            SEL_START: o_line = 1'b0;
            SEL_DATA:  o_line = i_ser_data;
            SEL_PAR:   o_line = i_parity;
            SEL_STOP:  o_line = 1'b1;
            default:   o_line = 1'b1;
        endcase
    end

endmodule : uart_tx_mux
`default_nettype wire

// File: rtl/uart_tx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fsm
// Description : UART transmit frame controller. Accepts a byte with a valid
//               strobe, latches it together with its parity configuration,
//               drives the external 8-bit serializer during the data phase
//               and sequences start / data / parity / stop bits onto the
//               line. One clock cycle equals one bit time.
// Ports       : clk        - baud clock
//               rst        - synchronous active-high reset
//               data_valid - one-cycle send request
//               p_data     - byte to send, LSB first
//               par_en     - 1 inserts a parity bit
//               par_typ    - 0 even, 1 odd parity
//               ser_en     - serializer enable (DATA state only)
//               ser_byte   - latched byte for the serializer
//               ser_data   - serial bit from the serializer
//               ser_done   - serializer flag, high at bit index 6
//               tx_out     - UART line, idle high
//               busy       - frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fsm
    import uart_tx_pkg::state_t,
           uart_tx_pkg::sel_t,
           uart_tx_pkg::IDLE,
           uart_tx_pkg::START,
           uart_tx_pkg::DATA,
           uart_tx_pkg::PARITY,
           uart_tx_pkg::STOP,
           uart_tx_pkg::SEL_START,
           uart_tx_pkg::SEL_DATA,
           uart_tx_pkg::SEL_PAR,
           uart_tx_pkg::SEL_STOP,
           uart_tx_pkg::parity_bit;
#(
    parameter int DATA_W = uart_tx_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] p_data,
    input  logic              par_en,
    input  logic              par_typ,
    output logic              ser_en,
    output logic [DATA_W-1:0] ser_byte,
    input  logic              ser_data,
    input  logic              ser_done,
    output logic              tx_out,
    output logic              busy
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [DATA_W-1:0]   r_byte;
    logic                r_par_en;
    logic                r_par_typ;
    logic                r_done_q;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_parity;
    sel_t                w_sel;

    // A request is only taken when the line is free (IDLE) or when the
    // current frame is on its final bit (STOP), which allows back-to-back
    // frames without an idle gap. Anything else is dropped.
    assign w_accept = data_valid && ((r_state == IDLE) || (r_state == STOP));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (data_valid) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                w_state_nxt = DATA;
            end
            DATA: begin
                // ser_done marks bit index 6; its registered copy is high
                // while bit 7 is on the line, so this is the last DATA cycle.
                if (r_done_q) begin
                    w_state_nxt = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                w_state_nxt = STOP;
            end
            STOP: begin
                w_state_nxt = data_valid ? START : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_byte    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Configuration is captured only at acceptance so that later
            // changes on par_en / par_typ cannot disturb a running frame.
            if (w_accept) begin
                r_byte    <= p_data;
                r_par_en  <= par_en;
                r_par_typ <= par_typ;
            end

            // Only a flag seen during DATA is kept; clearing it everywhere
            // else stops a stale flag from cutting the next frame short.
            r_done_q <= (r_state == DATA) ? ser_done : 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_parity = parity_bit(r_byte, r_par_typ);

    // Select is derived from the registered state alone, keeping tx_out
    // free of any path from data_valid or p_data.
    always_comb begin
        w_sel = SEL_STOP;
        case (r_state)
            IDLE:    w_sel = SEL_STOP;
            START:   w_sel = SEL_START;
            DATA:    w_sel = SEL_DATA;
            PARITY:  w_sel = SEL_PAR;
            STOP:    w_sel = SEL_STOP;
            default: w_sel = SEL_STOP;
        endcase
    end

    uart_tx_mux u_line_mux (
        .i_sel      (w_sel),
        .i_ser_data (ser_data),
        .i_parity   (w_parity),
        .o_line     (tx_out)
    );

    assign ser_en   = (r_state == DATA);
    assign ser_byte = r_byte;
    assign busy     = (r_state != IDLE);

endmodule : uart_tx_fsm
`default_nettype wire

// File: tb/tb_uart_tx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fsm
// Description : Self-checking bench for uart_tx_fsm. Contains a simple
//               serializer model feeding the DUT and a frame-level
//               reference model (queue of expected line bits) compared
//               against the DUT every cycle, plus literal frame checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fsm;

    localparam int DATA_W = 8;

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic              data_valid = 1'b0;
    logic [DATA_W-1:0] p_data     = '0;
    logic              par_en     = 1'b0;
    logic              par_typ    = 1'b0;
    logic              ser_en;
    logic [DATA_W-1:0] ser_byte;
    logic              ser_data;
    logic              ser_done;
    logic              tx_out;
    logic              busy;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fsm #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .p_data     (p_data),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .ser_en     (ser_en),
        .ser_byte   (ser_byte),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    // Serializer model: index held at 0 unless enabled, bit = byte[index],
    // done flag high while index is 6.
    logic [2:0] ser_idx = 3'd0;
    always @(posedge clk) begin
        if (rst || !ser_en) ser_idx <= 3'd0;
        else                ser_idx <= ser_idx + 3'd1;
    end
    assign ser_data = ser_byte[ser_idx];
    assign ser_done = (ser_idx == 3'd6);

    // Reference model: each accepted request appends its full frame of
    // line bits; one bit is consumed per clock.
    typedef struct packed { logic b; logic d; } slot_t;
    slot_t       q[$];
    logic [7:0]  m_byte = 8'h00;
    bit          m_acc;

    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
        slot_t s;
        s.b = 1'b0; s.d = 1'b0; q.push_back(s);
        for (int i = 0; i < 8; i++) begin
            s.b = d[i]; s.d = 1'b1; q.push_back(s);
        end
        if (pe) begin
            s.b = (($countones(d) % 2) == 1) ^ pt; s.d = 1'b0; q.push_back(s);
        end
        s.b = 1'b1; s.d = 1'b0; q.push_back(s);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_byte = 8'h00;
        end else begin
            // Free line, or only the stop bit left: a request is taken.
            m_acc = data_valid && (q.size() <= 1);
            if (q.size() > 0) void'(q.pop_front());
            if (m_acc) begin
                push_frame(p_data, par_en, par_typ);
                m_byte = p_data;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model tx_out", {31'd0, tx_out}, (q.size() > 0) ? {31'd0, q[0].b} : 32'd1);
            chk("model busy",   {31'd0, busy},   (q.size() > 0) ? 32'd1 : 32'd0);
            chk("model ser_en", {31'd0, ser_en}, (q.size() > 0) ? {31'd0, q[0].d} : 32'd0);
            chk("model ser_byte", {24'd0, ser_byte}, {24'd0, m_byte});
        end
    end

    // Called at a negedge: request a frame and record 11 cycles of line and
    // busy, first cycle in the MSB.
    task automatic send_capture(input logic [7:0] d, input logic pe, input logic pt,
                                output logic [10:0] txs, output logic [10:0] bs);
        data_valid = 1'b1; p_data = d; par_en = pe; par_typ = pt;
        txs = '0; bs = '0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 0) data_valid = 1'b0;
            txs = {txs[9:0], tx_out};
            bs  = {bs[9:0], busy};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [10:0] txs, bs;
    logic        busy_and;

    initial begin
        // Reset and idle.
        repeat (2) @(negedge clk);
        chk("reset tx_out",   {31'd0, tx_out},   32'd1);
        chk("reset busy",     {31'd0, busy},     32'd0);
        chk("reset ser_en",   {31'd0, ser_en},   32'd0);
        chk("reset ser_byte", {24'd0, ser_byte}, 32'd0);
        chk_on = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle line", {29'd0, tx_out, busy, ser_en}, 32'b100);
        end

        // 0xA5 even, odd, and without parity.
        send_capture(8'hA5, 1'b1, 1'b0, txs, bs);
        chk("A5 even frame", {21'd0, txs}, {21'd0, 11'b01010010101});
        chk("A5 even busy",  {21'd0, bs},  {21'd0, 11'h7FF});
        repeat (2) @(negedge clk);
        send_capture(8'hA5, 1'b1, 1'b1, txs, bs);
        chk("A5 odd frame", {21'd0, txs}, {21'd0, 11'b01010010111});
        repeat (2) @(negedge clk);
        send_capture(8'hA5, 1'b0, 1'b0, txs, bs);
        chk("A5 nopar frame", {21'd0, txs}, {21'd0, 11'b01010010111});
        chk("A5 nopar busy",  {21'd0, bs},  {21'd0, 11'b11111111110});
        repeat (2) @(negedge clk);

        // Back-to-back: 0x3C, then 0xFF in the STOP cycle, then an ignored
        // request during DATA of the second frame.
        data_valid = 1'b1; p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0;
        busy_and = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            if (i == 1)  data_valid = 1'b0;
            if (i == 10) begin
                chk("b2b stop bit", {31'd0, tx_out}, 32'd1);
                data_valid = 1'b1; p_data = 8'hFF; par_en = 1'b1; par_typ = 1'b0;
            end
            if (i == 11) begin
                chk("b2b start bit", {31'd0, tx_out}, 32'd0);
                chk("b2b busy",      {31'd0, busy},   32'd1);
                data_valid = 1'b0;
            end
            if (i == 13) begin data_valid = 1'b1; p_data = 8'h55; end
            if (i == 14) data_valid = 1'b0;
            if (i <= 21) busy_and = busy_and & busy;
            if (i == 22) chk("b2b ends idle", {30'd0, tx_out, busy}, 32'b10);
        end
        chk("b2b busy held", {31'd0, busy_and}, 32'd1);
        repeat (3) @(negedge clk);
        chk("b2b no third frame", {31'd0, busy}, 32'd0);

        // Reset on the 4th DATA cycle of 0x0F.
        data_valid = 1'b1; p_data = 8'h0F; par_en = 1'b0; par_typ = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) data_valid = 1'b0;
            if (i == 5) rst = 1'b1;
            if (i == 6) begin
                chk("abort state", {29'd0, tx_out, busy, ser_en}, 32'b100);
                rst = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        send_capture(8'h81, 1'b1, 1'b1, txs, bs);
        chk("81 odd frame", {21'd0, txs}, {21'd0, 11'b01000000111});
        chk("81 odd busy",  {21'd0, bs},  {21'd0, 11'h7FF});
        repeat (2) @(negedge clk);

        // Reset and request together: the request is dropped.
        rst = 1'b1; data_valid = 1'b1; p_data = 8'hC3;
        @(negedge clk);
        chk("rst wins busy", {31'd0, busy}, 32'd0);
        rst = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        chk("rst wins no frame", {30'd0, tx_out, busy}, 32'b10);
        chk("rst wins ser_byte", {24'd0, ser_byte}, 32'd0);

        // Configuration changes mid-frame are ignored.
        data_valid = 1'b1; p_data = 8'h01; par_en = 1'b1; par_typ = 1'b0;
        txs = '0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 1) data_valid = 1'b0;
            if (i == 3) begin par_typ = 1'b1; par_en = 1'b0; end
            txs = {txs[9:0], tx_out};
        end
        chk("01 cfg locked frame", {21'd0, txs}, {21'd0, 11'b01000000011});
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_fsm
`default_nettype wire
